// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row strobe, column sync, frame debounce
// and press/release/auto-repeat event generation.
module keypad_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SETTLE_CYC      = 16,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8,
  localparam int KW = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [COLS-1:0] cols,
  output logic [ROWS-1:0] rows,
  output logic [KW-1:0]   key_code,
  output logic            key_event,
  output logic            key_repeat,
  output logic            key_release,
  output logic            key_down,
  output logic            multi_key
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(SETTLE_CYC);
  localparam int FW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int PW = $clog2(RMAX + 1);

  typedef enum logic [1:0] {
    K_NONE   = 2'd0,
    K_SINGLE = 2'd1,
    K_MULTI  = 2'd2
  } kind_t;

  logic [COLS-1:0] r_sync1;
  logic [COLS-1:0] r_sync2;
  logic            r_run;
  logic [RW-1:0]   r_row;
  logic [DW-1:0]   r_dwell;
  logic [ROWS-1:0] r_rows;
  logic [1:0]      r_acc;
  logic [KW-1:0]   r_first;
  kind_t           r_cand_kind;
  logic [KW-1:0]   r_cand_code;
  logic [FW-1:0]   r_cnt;
  kind_t           r_st_kind;
  logic [KW-1:0]   r_st_code;
  logic [KW-1:0]   r_code;
  logic            r_event;
  logic            r_repeat;
  logic            r_release;
  logic            r_down;
  logic            r_multi;
  logic            r_pend;
  logic [PW-1:0]   r_rpt_cnt;
  logic            r_rpt_arm;

  logic            w_sample;
  logic            w_last;
  logic [RW-1:0]   w_row_nxt;
  logic [COLS-1:0] w_pressed;
  logic [3:0]      w_row_pop;
  logic [CW-1:0]   w_first_col;
  logic [1:0]      w_row_sat;
  logic [2:0]      w_acc_sum;
  logic [1:0]      w_acc_nxt;
  logic [KW-1:0]   w_code;
  logic [KW-1:0]   w_first_nxt;
  kind_t           w_res_kind;
  logic [KW-1:0]   w_res_code;
  logic            w_frame;
  logic            w_same;
  logic [FW-1:0]   w_cnt_nxt;
  kind_t           w_cand_kind_nxt;
  logic [KW-1:0]   w_cand_code_nxt;
  logic            w_commit;
  logic            w_was_s;
  logic            w_is_s;
  logic [PW-1:0]   w_rpt_nxt;
  logic [PW-1:0]   w_rpt_lim;
  logic            w_rpt_hit;

  assign w_sample  = r_run &&
                     (r_dwell == DW'(SETTLE_CYC - 1));
  assign w_last    = (r_row == RW'(ROWS - 1));
  assign w_row_nxt = w_last ? '0 : r_row + RW'(1);
  assign w_frame   = w_sample && w_last;
  assign w_pressed = ~r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= cols;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run   <= 1'b0;
      r_row   <= '0;
      r_dwell <= '0;
      r_rows  <= '1;
    end else if (!r_run) begin
      r_run  <= 1'b1;
      r_rows <= ~ROWS'(1);
    end else if (w_sample) begin
      r_dwell <= '0;
      r_row   <= w_row_nxt;
      r_rows  <= ~(ROWS'(1) << w_row_nxt);
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  // Scan from the top column down so the lowest pressed column wins.
  always_comb begin
    w_row_pop   = '0;
    w_first_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (w_pressed[c]) begin
        w_row_pop   = w_row_pop + 4'd1;
        w_first_col = CW'(c);
      end
    end
  end

  assign w_row_sat = (w_row_pop > 4'd1) ?
                     2'd2 : w_row_pop[1:0];
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, w_row_sat};
  assign w_acc_nxt = (w_acc_sum > 3'd1) ?
                     2'd2 : w_acc_sum[1:0];
  assign w_code    = KW'(r_row) * KW'(COLS) +
                     KW'(w_first_col);
  assign w_first_nxt = (r_acc == 2'd0 &&
                        w_row_pop != 4'd0) ?
                       w_code : r_first;
  assign w_res_kind = kind_t'(w_acc_nxt);
  assign w_res_code = (w_acc_nxt == 2'd1) ?
                      w_first_nxt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_first <= '0;
    end else if (w_sample) begin
      r_acc   <= w_last ? 2'd0 : w_acc_nxt;
      r_first <= w_last ? '0 : w_first_nxt;
    end
  end

  assign w_same = (w_res_kind == r_cand_kind) &&
                  (w_res_code == r_cand_code);
  assign w_cnt_nxt = !w_same ? FW'(1) :
    (r_cnt == FW'(DEBOUNCE_FRAMES)) ?
    r_cnt : r_cnt + FW'(1);
  assign w_cand_kind_nxt = w_same ?
                           r_cand_kind : w_res_kind;
  assign w_cand_code_nxt = w_same ?
                           r_cand_code : w_res_code;
  assign w_commit = w_frame &&
    (w_cnt_nxt == FW'(DEBOUNCE_FRAMES)) &&
    ({w_cand_kind_nxt, w_cand_code_nxt} !=
     {r_st_kind, r_st_code});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand_kind <= K_NONE;
      r_cand_code <= '0;
      r_cnt       <= '0;
    end else if (w_frame) begin
      r_cand_kind <= w_cand_kind_nxt;
      r_cand_code <= w_cand_code_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign w_was_s   = (r_st_kind == K_SINGLE);
  assign w_is_s    = (w_cand_kind_nxt == K_SINGLE);
  assign w_rpt_nxt = r_rpt_cnt + PW'(1);
  assign w_rpt_lim = r_rpt_arm ? PW'(REPEAT_PERIOD) :
                     PW'(REPEAT_DELAY);
  assign w_rpt_hit = (w_rpt_nxt == w_rpt_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st_kind <= K_NONE;
      r_st_code <= '0;
      r_code    <= '0;
      r_event   <= 1'b0;
      r_repeat  <= 1'b0;
      r_release <= 1'b0;
      r_down    <= 1'b0;
      r_multi   <= 1'b0;
      r_pend    <= 1'b0;
      r_rpt_cnt <= '0;
      r_rpt_arm <= 1'b0;
    end else begin
      r_event   <= 1'b0;
      r_repeat  <= 1'b0;
      r_release <= 1'b0;
      // Deferred press half of a key-to-key change.
      if (r_pend) begin
        r_pend  <= 1'b0;
        r_event <= 1'b1;
        r_code  <= r_st_code;
      end
      if (w_commit) begin
        r_st_kind <= w_cand_kind_nxt;
        r_st_code <= w_cand_code_nxt;
        r_down    <= (w_cand_kind_nxt == K_SINGLE);
        r_multi   <= (w_cand_kind_nxt == K_MULTI);
        r_rpt_cnt <= '0;
        r_rpt_arm <= 1'b0;
        unique case (1'b1)
          (w_was_s && w_is_s): begin
            r_release <= 1'b1;
            r_code    <= r_st_code;
            r_pend    <= 1'b1;
          end
          (w_was_s && !w_is_s): begin
            r_release <= 1'b1;
            r_code    <= r_st_code;
          end
          (!w_was_s && w_is_s): begin
            r_event <= 1'b1;
            r_code  <= w_cand_code_nxt;
          end
          default: ;
        endcase
      end else if (w_frame && REPEAT_EN != 0 &&
                   w_was_s) begin
        if (w_rpt_hit) begin
          r_event   <= 1'b1;
          r_repeat  <= 1'b1;
          r_rpt_cnt <= '0;
          r_rpt_arm <= 1'b1;
        end else begin
          r_rpt_cnt <= w_rpt_nxt;
        end
      end
    end
  end

  assign rows        = r_rows;
  assign key_code    = r_code;
  assign key_event   = r_event;
  assign key_repeat  = r_repeat;
  assign key_release = r_release;
  assign key_down    = r_down;
  assign multi_key   = r_multi;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus random
// key patterns checked against an event-level model.
module tb_keypad_scanner;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SC   = 4;
  localparam int DEB  = 3;
  localparam int RD   = 6;
  localparam int RP   = 2;
  localparam int FR   = ROWS * SC;
  localparam int LAT  = 2 + (DEB + 1) * FR;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys = '0;
  logic [3:0]  rows0, rows1, cols0, cols1;
  logic [3:0]  code0, code1;
  logic        ev0, rp0, rl0, dn0, mk0;
  logic        ev1, rp1, rl1, dn1, mk1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int n_ev0 = 0, n_rel0 = 0, n_rep0 = 0;
  int n_ev1 = 0, n_rel1 = 0, n_rep1 = 0;
  int n_both = 0;
  int t_ev0 = 0, t_ev1 = 0;
  int c_ev0 = 0, c_rel0 = 0, c_ev1 = 0, c_rel1 = 0;
  int rep_t[$];
  int rep_c[$];
  int obs0[$];
  int obs1[$];
  int expq[$];
  logic log_en = 1'b0;
  int pk = 0, pc = 0;

  function automatic logic [3:0] pad(
    input logic [3:0] r, input logic [15:0] k);
    logic [3:0] c;
    c = '1;
    for (int rr = 0; rr < 4; rr++)
      if (!r[rr])
        for (int cc = 0; cc < 4; cc++)
          if (k[rr*4+cc]) c[cc] = 1'b0;
    return c;
  endfunction

  assign cols0 = pad(rows0, keys);
  assign cols1 = pad(rows1, keys);

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYC(SC),
    .DEBOUNCE_FRAMES(DEB), .REPEAT_EN(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .cols(cols0),
    .rows(rows0), .key_code(code0),
    .key_event(ev0), .key_repeat(rp0),
    .key_release(rl0), .key_down(dn0),
    .multi_key(mk0)
  );

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYC(SC),
    .DEBOUNCE_FRAMES(DEB), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .cols(cols1),
    .rows(rows1), .key_code(code1),
    .key_event(ev1), .key_repeat(rp1),
    .key_release(rl1), .key_down(dn1),
    .multi_key(mk1)
  );

  initial forever #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;

  initial forever begin
    @(negedge clk);
    if ((ev0 && rl0) || (ev1 && rl1)) n_both++;
    if (ev0) begin
      if (rp0) n_rep0++;
      else begin
        n_ev0++; t_ev0 = cyc; c_ev0 = int'(code0);
        if (log_en) obs0.push_back(16 + int'(code0));
      end
    end
    if (rl0) begin
      n_rel0++; c_rel0 = int'(code0);
      if (log_en) obs0.push_back(32 + int'(code0));
    end
    if (ev1) begin
      if (rp1) begin
        n_rep1++;
        rep_t.push_back(cyc);
        rep_c.push_back(int'(code1));
      end else begin
        n_ev1++; t_ev1 = cyc; c_ev1 = int'(code1);
        if (log_en) obs1.push_back(16 + int'(code1));
      end
    end
    if (rl1) begin
      n_rel1++; c_rel1 = int'(code1);
      if (log_en) obs1.push_back(32 + int'(code1));
    end
  end

  task automatic check(input string tag,
                       input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic model(input logic [15:0] k);
    int nk, nc;
    nk = $countones(k);
    nc = 0;
    for (int i = 15; i >= 0; i--) if (k[i]) nc = i;
    if (nk > 1) nk = 2;
    if (nk != 1) nc = 0;
    if (pk == 1 && (nk != 1 || nc != pc))
      expq.push_back(32 + pc);
    if (nk == 1 && (pk != 1 || nc != pc))
      expq.push_back(16 + nc);
    pk = nk;
    pc = nc;
  endtask

  initial begin
    int b, br, b1, br1, tp, e;
    logic [3:0] er;
    logic [15:0] pat;
    int a, s;

    tick(3);
    check("rst_rows", int'(rows0), 15);
    check("rst_outs", int'({code1, ev1, rp1, rl1, dn1, mk1}), 0);
    rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick(1);
      er = ~(4'b1 << ((n - 1) / 4 % 4));
      check("scan_rows", int'(rows0), int'(er));
    end
    tick(5 * FR);
    check("idle_events",
          n_ev0 + n_ev1 + n_rel0 + n_rel1 + n_rep1, 0);
    check("idle_levels", int'({dn0, mk0, dn1, mk1}), 0);

    b = n_ev0;
    keys = 16'h1 << 6;
    tp = cyc;
    for (int i = 0; i < LAT + 8 && n_ev0 == b; i++) tick(1);
    check("s2_press_cnt", n_ev0 - b, 1);
    check("s2_latency_ok", int'((t_ev0 - tp) <= LAT), 1);
    check("s2_code", c_ev0, 6);
    check("s2_down", int'(dn0), 1);
    tick(12 * FR);
    check("s2_single_event", n_ev0 - b, 1);
    check("s2_no_repeat", n_rep0, 0);
    br = n_rel0;
    keys = '0;
    for (int i = 0; i < LAT + 8 && n_rel0 == br; i++) tick(1);
    check("s2_release_cnt", n_rel0 - br, 1);
    check("s2_release_code", c_rel0, 6);
    check("s2_up", int'(dn0), 0);

    tick(4 * FR);
    b = n_ev0;
    br = n_rel0;
    for (int i = 0; i < 16; i++) begin
      keys[0] = ~keys[0];
      tick(5);
    end
    check("s3_bounce_ev", n_ev0 - b, 0);
    check("s3_bounce_rel", n_rel0 - br, 0);
    keys[0] = 1'b1;
    for (int i = 0; i < LAT + 8 && n_ev0 == b; i++) tick(1);
    tick(2 * FR);
    check("s3_press_cnt", n_ev0 - b, 1);
    check("s3_code", c_ev0, 0);
    br = n_rel0;
    keys = '0;
    for (int i = 0; i < LAT + 8 && n_rel0 == br; i++) tick(1);
    check("s3_release_cnt", n_rel0 - br, 1);

    tick(4 * FR);
    b = n_ev0;
    br = n_rel0;
    keys = 16'h0021;
    tick(LAT + FR);
    check("s4_multi", int'(mk0), 1);
    check("s4_down", int'(dn0), 0);
    check("s4_no_pulses", (n_ev0 - b) + (n_rel0 - br), 0);
    keys = 16'h0020;
    for (int i = 0; i < LAT + 8 && n_ev0 == b; i++) tick(1);
    check("s4_press_cnt", n_ev0 - b, 1);
    check("s4_code", c_ev0, 5);
    check("s4_multi_off", int'(mk0), 0);
    check("s4_down_on", int'(dn0), 1);
    br = n_rel0;
    keys = '0;
    for (int i = 0; i < LAT + 8 && n_rel0 == br; i++) tick(1);
    check("s4_release_code", c_rel0, 5);

    tick(4 * FR);
    b1 = n_ev1;
    rep_t.delete();
    rep_c.delete();
    keys = 16'h8000;
    for (int i = 0; i < LAT + 8 && n_ev1 == b1; i++) tick(1);
    check("s5_press_cnt", n_ev1 - b1, 1);
    check("s5_code", c_ev1, 15);
    tp = t_ev1;
    tick(10 * FR + 4);
    br1 = n_rel1;
    keys = '0;
    for (int i = 0; i < LAT + 8 && n_rel1 == br1; i++) tick(1);
    check("s5_release_cnt", n_rel1 - br1, 1);
    check("s5_release_code", c_rel1, 15);
    check("s5_repeat_n", int'(rep_t.size() >= 3), 1);
    for (int k = 0; k < 3 && k < rep_t.size(); k++) begin
      check("s5_repeat_time", rep_t[k] - tp, (RD + RP * k) * FR);
      check("s5_repeat_code", rep_c[k], 15);
    end
    e = n_ev1 + n_rep1;
    tick(20 * FR);
    check("s5_quiet_after", n_ev1 + n_rep1 - e, 0);
    check("s5_single_release", n_rel1 - br1, 1);

    b1 = n_ev1;
    keys = 16'h0008;
    for (int i = 0; i < LAT + 8 && n_ev1 == b1; i++) tick(1);
    check("s6_first_press", c_ev1, 3);
    tick(2 * FR);
    br = n_rel0;
    br1 = n_rel1;
    rst_n = 1'b0;
    #1;
    check("s6_rst_down", int'(dn1), 0);
    check("s6_rst_code", int'(code1), 0);
    check("s6_rst_pulses", int'({ev1, rp1, rl1}), 0);
    check("s6_rst_rows", int'(rows1), 15);
    tick(2);
    rst_n = 1'b1;
    b = n_ev0;
    b1 = n_ev1;
    for (int i = 0; i < LAT + 8 && n_ev1 == b1; i++) tick(1);
    tick(2 * FR);
    check("s6_fresh_press", n_ev1 - b1, 1);
    check("s6_fresh_code", c_ev1, 3);
    check("s6_fresh_press0", n_ev0 - b, 1);
    check("s6_no_release", (n_rel0 - br) + (n_rel1 - br1), 0);
    keys = '0;
    tick(6 * FR);

    pk = 0;
    pc = 0;
    obs0.delete();
    obs1.delete();
    expq.delete();
    log_en = 1'b1;
    for (int h = 0; h < 20; h++) begin
      s = $urandom_range(0, 3);
      a = $urandom_range(0, 15);
      pat = '0;
      if (s == 1 || s == 2) pat[a] = 1'b1;
      if (s == 3) begin
        pat[a] = 1'b1;
        pat[(a + $urandom_range(1, 15)) % 16] = 1'b1;
      end
      keys = pat;
      model(pat);
      tick($urandom_range(5, 8) * FR);
    end
    keys = '0;
    model(16'h0);
    tick(6 * FR);
    log_en = 1'b0;
    check("rnd_count0", obs0.size(), expq.size());
    for (int i = 0; i < obs0.size() && i < expq.size(); i++)
      check("rnd_event0", obs0[i], expq[i]);
    check("rnd_count1", obs1.size(), expq.size());
    for (int i = 0; i < obs1.size() && i < expq.size(); i++)
      check("rnd_event1", obs1[i], expq[i]);

    check("no_coincide", n_both, 0);
    check("no_repeat_u0", n_rep0, 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Parametrised matrix keypad scanner that replaces the fixed 4x4 scanner. It drives one row low at a time, samples the active-low columns through a synchroniser, and debounces whole scan frames. It emits press, release and auto-repeat events with a registered key code. The block sits between the board keypad pins and the game control logic, which consumes key events, for example paddle up/down.

Parameters:
ROWS, 4, number of matrix rows (2..8)
COLS, 4, number of matrix columns (2..8)
SETTLE_CYC, 16, clk cycles each row is driven before its columns are sampled (>=2)
DEBOUNCE_FRAMES, 4, consecutive identical frames required to commit a new state (>=1)
REPEAT_EN, 1, 1 enables auto-repeat events while a single key is held
REPEAT_DELAY, 32, frames from press event to first repeat event
REPEAT_PERIOD, 8, frames between subsequent repeat events
KW, $clog2(ROWS*COLS), key code width (derived, not overridable)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cols  in  COLS  column inputs, active low (pulled up, low = pressed key in driven row)
rows  out  ROWS  row drives, active low, at most one bit low
key_code  out  KW  code of last pressed/released key = row*COLS + col
key_event  out  1  one-cycle pulse: press or repeat of key_code
key_repeat  out  1  qualifies key_event: 1 = auto-repeat, 0 = initial press
key_release  out  1  one-cycle pulse: key_code released
key_down  out  1  level: debounced state is exactly one key
multi_key  out  1  level: debounced state is two or more keys

Behaviour:
- Reset, asynchronous, rst_n=0:
  - rows = all ones; key_code = 0; all other outputs = 0.
  - Row index, dwell counter, synchroniser, debounce and repeat counters are all cleared.
  - No events are emitted as a consequence of reset.
- Synchroniser: cols passes through 2 flops. "Sample" below means the synchroniser output.
- Scan:
  - First cycle after reset release: rows = ~(1<<0).
  - Dwell counter runs 0..SETTLE_CYC-1; sample is taken when dwell = SETTLE_CYC-1.
  - Next cycle advances the row index, wrapping ROWS-1 -> 0.
  - One frame = ROWS*SETTLE_CYC cycles.
- Frame accumulation: a per-frame popcount of pressed bits is kept, saturating at 2.
  - The first pressed code is kept, priority lowest row then lowest column.
  - Frame result after row ROWS-1 is sampled: NONE, SINGLE(code) or MULTI.
- Debounce:
  - Candidate register plus stable counter.
  - Result equal to candidate: counter increments, saturating at DEBOUNCE_FRAMES.
  - Otherwise: candidate <= result, counter <= 1.
  - The cycle the counter reaches DEBOUNCE_FRAMES and candidate != committed state, committed state <= candidate (the commit cycle).
- Event generation on commit, all pulses registered and one cycle wide:
  - NONE/MULTI -> SINGLE(k): key_code<=k, key_event=1, key_repeat=0.
  - SINGLE(k) -> NONE/MULTI: key_code<=k, key_release=1.
  - SINGLE(k) -> SINGLE(j), j!=k: release k on commit cycle, press j (key_code<=j) on the next cycle.
  - NONE <-> MULTI: no pulses.
  - key_down and multi_key follow committed state, updating on the commit cycle.
- Auto-repeat, REPEAT_EN=1:
  - A frame counter starts at the press event.
  - When it reaches REPEAT_DELAY frames: key_event=1, key_repeat=1, key_code unchanged.
  - Thereafter a repeat event every REPEAT_PERIOD frames.
  - The counter clears on any commit.
  - With REPEAT_EN=0, repeat is never asserted.
- Press latency from stable cols: at most 2 + (DEBOUNCE_FRAMES+1)*frame cycles.
- key_event and key_release are never high in the same cycle.

Test Plan:
All scenarios use ROWS=4, COLS=4, SETTLE_CYC=4, DEBOUNCE_FRAMES=3, REPEAT_DELAY=6, REPEAT_PERIOD=2 (frame = 16 cycles).
1. Reset, then release, no keys pressed.
   -> rows=1111 during reset; 1110 on the first cycle after release.
   -> Then 1101, 1011, 0111, each held 4 cycles, then wraps.
   -> All outputs remain 0.
2. Hold row1/col2 pressed, REPEAT_EN=0.
   -> Exactly one key_event, key_repeat=0, key_code=6, within 2+4*16 cycles; key_down=1.
   -> Release the key -> one key_release with key_code=6; key_down=0.
3. Toggle col0 for row0 every 5 cycles for 80 cycles, then hold stable.
   -> No events during bouncing.
   -> Exactly one key_event with key_code=0 after settling.
4. Press keys 0 and 5 together -> multi_key=1, key_down=0, no pulses.
   -> Release key 0 -> key_event with key_code=5; multi_key=0.
5. Hold key 15 with REPEAT_EN=1.
   -> Press event, then repeat events at 6, 8 and 10 frames after the press, each with key_repeat=1 and key_code=15.
   -> Release -> one key_release; no further events.
6. Drive rst_n=0 mid-hold of key 3.
   -> key_down, key_code and all pulses go to 0 immediately.
   -> After reset release with the key still held: a fresh press event after debounce, and no key_release.
